fir_decimator: RTL and testbench

Integrate-and-dump decimator directly downstream of the single-tap FIR multiplier stage. Consumes the signed product stream one sample per cycle, sums `DECIM` consecutive samples, then rounds, scales and clips the sum to `BW_OUT` bits. Results go into a small output FIFO with a valid/ready handshake, so the slower pad-level readout can apply backpressure without stalling the FIR.

---
 rtl/fir_decimator.sv | 143 ++++++++++++++
 tb/tb_fir_decimator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// fir_decimator: integrate-and-dump decimator behind the single-tap FIR multiplier.
//
// The block sums DECIM consecutive signed samples. It then rounds the sum, shifts it right
// arithmetically by SHIFT and clips it to BW_OUT bits. Each result is pushed into a small
// output FIFO that has a valid/ready read side.
//
// Optional feature macro: FIR_DECIM_SATURATE_EN
//   defined   -> out-of-range results clamp to the signed BW_OUT limits
//   undefined -> out-of-range results keep their low BW_OUT bits (two's-complement wrap)
// In both builds clipped_o is set whenever a result is out of range.
//
// Ports:
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   in_valid_i   sample qualifier
//   in_data_i    signed input sample, BW_IN bits
//   out_valid_o  FIFO non-empty
//   out_ready_i  consumer accepts the head entry
//   out_data_o   signed FIFO head, BW_OUT bits (0 when empty)
//   clipped_o    sticky: a result was saturated or wrapped
//   dropped_o    sticky: a result was lost to a full FIFO
module fir_decimator #(
    parameter int unsigned BW_IN      = 8,
    parameter int unsigned DECIM      = 4,
    parameter int unsigned BW_ACC     = 10,
    parameter int unsigned SHIFT      = 1,
    parameter int unsigned BW_OUT     = 8,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid_i,
    input  logic signed [BW_IN-1:0]  in_data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [BW_OUT-1:0] out_data_o,
    output logic                     clipped_o,
    output logic                     dropped_o
);

    localparam int unsigned CntW = $clog2(DECIM);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    // One extra bit so that adding the rounding constant can never overflow.
    localparam int unsigned SumW = BW_ACC + 1;

    localparam logic [CntW-1:0]        CntLast = CntW'(DECIM - 1);
    localparam logic [PtrW:0]          CntFull = (PtrW + 1)'(FIFO_DEPTH);
    localparam logic signed [SumW-1:0] RndC    = SumW'((SHIFT == 0) ? 0 : (1 << (SHIFT - 1)));
    localparam logic signed [SumW-1:0] OutMax  = SumW'((1 << (BW_OUT - 1)) - 1);
    localparam logic signed [SumW-1:0] OutMin  = -OutMax - SumW'(1);

    logic [CntW-1:0]        cnt_q, cnt_d;
    logic signed [BW_ACC-1:0] acc_q, acc_d;
    logic signed [SumW-1:0] sum, rounded, scaled;
    logic                   dump, over_hi, over_lo;
    logic [BW_OUT-1:0]      result;

    logic [BW_OUT-1:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]          count_q;
    logic                   full, pop, push, drop;

    // Datapath: accumulate, round, scale and clip.
    always_comb begin
        dump    = in_valid_i && (cnt_q == CntLast);
        // Both size casts are applied to signed operands, so they sign-extend.
        sum     = SumW'(acc_q) + SumW'(in_data_i);
        rounded = sum + RndC;
        scaled  = rounded >>> SHIFT;
        over_hi = scaled > OutMax;
        over_lo = scaled < OutMin;
`ifdef FIR_DECIM_SATURATE_EN
        if (over_hi) begin
            result = OutMax[BW_OUT-1:0];
        end else if (over_lo) begin
            result = OutMin[BW_OUT-1:0];
        end else begin
            result = scaled[BW_OUT-1:0];
        end
`else
        result = scaled[BW_OUT-1:0];
`endif

        cnt_d = cnt_q;
        acc_d = acc_q;
        if (in_valid_i) begin
            cnt_d = dump ? '0 : cnt_q + 1'b1;
            // The accumulator clears on the dump edge, so the next sample starts a fresh frame.
            acc_d = dump ? '0 : acc_q + BW_ACC'(in_data_i);
        end
    end

    // FIFO control. When the FIFO is full, a pop in the same cycle frees a slot for the push.
    always_comb begin
        full = (count_q == CntFull);
        pop  = (count_q != '0) && out_ready_i;
        push = dump && (!full || pop);
        drop = dump && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            clipped_o <= 1'b0;
            dropped_o <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (dump && (over_hi || over_lo)) begin
                clipped_o <= 1'b1;
            end
            if (drop) begin
                dropped_o <= 1'b1;
            end
        end
    end

    // Storage needs no reset: the read mux shows 0 whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= result;
        end
    end

    assign out_valid_o = (count_q != '0);
    assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed testbench for fir_decimator with default parameters.
// Expected values are hand-computed as ((sum of 4 samples) + 1) >>> 1.
module tb_fir_decimator;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              clipped;
    logic              dropped;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_decimator dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .clipped_o   (clipped),
        .dropped_o   (dropped)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%02h) expected %0d (0x%02h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_valid",   {7'd0, out_valid}, 8'd0);
        check("rst_data",    out_data,          8'd0);
        check("rst_clipped", {7'd0, clipped},   8'd0);
        check("rst_dropped", {7'd0, dropped},   8'd0);
        reset = 1'b0;

        // 10+20+30+40 = 100 -> (100+1)>>1 = 50, one-cycle valid pulse
        step(1'b1, 8'd10, 1'b1);
        step(1'b1, 8'd20, 1'b1);
        step(1'b1, 8'd30, 1'b1);
        check("s1_no_early", {7'd0, out_valid}, 8'd0);
        step(1'b1, 8'd40, 1'b1);
        check("s1_valid", {7'd0, out_valid}, 8'd1);
        check("s1_data",  out_data,          8'd50);
        step(1'b0, 8'd0, 1'b1);
        check("s1_pulse_end", {7'd0, out_valid}, 8'd0);
        check("s1_data_zero", out_data,          8'd0);
        check("s1_clipped",   {7'd0, clipped},   8'd0);

        // -3-3-3-2 = -11 -> (-10)>>>1 = -5
        step(1'b1, 8'hFD, 1'b1);
        step(1'b1, 8'hFD, 1'b1);
        step(1'b1, 8'hFD, 1'b1);
        step(1'b1, 8'hFE, 1'b1);
        check("s2_valid",   {7'd0, out_valid}, 8'd1);
        check("s2_data",    out_data,          8'hFB);
        check("s2_clipped", {7'd0, clipped},   8'd0);
        step(1'b0, 8'd0, 1'b1);

        // 4 x 127 = 508 -> 509>>1 = 254, out of range
        for (int i = 0; i < 4; i++) step(1'b1, 8'd127, 1'b1);
`ifdef FIR_DECIM_SATURATE_EN
        check("s3_data", out_data, 8'h7F);
`else
        check("s3_data", out_data, 8'hFE);
`endif
        check("s3_clipped", {7'd0, clipped}, 8'd1);
        step(1'b0, 8'd0, 1'b1);

        // Backpressure: 3 frames of 1s -> two results of 2 held, third dropped
        do_reset();
        check("s4_clip_cleared", {7'd0, clipped}, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
        check("s4_first_valid", {7'd0, out_valid}, 8'd1);
        check("s4_first_data",  out_data,          8'd2);
        for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
        check("s4_no_drop_yet", {7'd0, dropped}, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
        check("s4_dropped", {7'd0, dropped}, 8'd1);
        step(1'b0, 8'd0, 1'b0);
        check("s4_hold_valid", {7'd0, out_valid}, 8'd1);
        check("s4_hold_data",  out_data,          8'd2);
        step(1'b0, 8'd0, 1'b1);
        check("s4_pop1_valid", {7'd0, out_valid}, 8'd1);
        check("s4_pop1_data",  out_data,          8'd2);
        step(1'b0, 8'd0, 1'b1);
        check("s4_empty", {7'd0, out_valid}, 8'd0);
        check("s4_clipped", {7'd0, clipped}, 8'd0);

        // Full FIFO (2, 4), ready raised exactly on the dump of frame (3,3,3,3) -> 6
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'd1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'd2, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'd3, 1'b0);
        step(1'b1, 8'd3, 1'b1);
        check("s5_no_drop", {7'd0, dropped},   8'd0);
        check("s5_valid",   {7'd0, out_valid}, 8'd1);
        check("s5_head",    out_data,          8'd4);
        step(1'b0, 8'd0, 1'b1);
        check("s5_tail_valid", {7'd0, out_valid}, 8'd1);
        check("s5_tail",       out_data,          8'd6);
        step(1'b0, 8'd0, 1'b1);
        check("s5_empty", {7'd0, out_valid}, 8'd0);

        // Reset mid-frame discards the partial sum: 4 x 8 = 32 -> 33>>1 = 16
        do_reset();
        step(1'b1, 8'd5, 1'b1);
        step(1'b1, 8'd5, 1'b1);
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 8'd8, 1'b1);
        check("s6_no_early", {7'd0, out_valid}, 8'd0);
        step(1'b1, 8'd8, 1'b1);
        check("s6_valid",   {7'd0, out_valid}, 8'd1);
        check("s6_data",    out_data,          8'd16);
        check("s6_clipped", {7'd0, clipped},   8'd0);
        check("s6_dropped", {7'd0, dropped},   8'd0);
        step(1'b0, 8'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
